irom_arbiter: RTL and testbench

//  Shares the single instruction-ROM read port (HADDR/HRDATA, combinational

---
 rtl/irom_arbiter.sv | 140 ++++++++++++++
 tb/tb_irom_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irom_arbiter.sv
// Shares the single combinational instruction-ROM read port between the fetch stage (IF) and the load unit (MEM).
// Fixed MEM priority; IF is forced through after STARVE_LIMIT consecutive losses.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for a request; winner picked and address latched
//   ACCESS | HADDR presents the winner's address, HRDATA captured at end
//   RESP   | winner's ready pulses for this single cycle
module irom_arbiter #(
  parameter int unsigned ROM_SIZE     = 256,
  parameter logic [63:0] ROM_START    = 64'h0,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_ready,
  output logic [63:0] if_rdata,
  output logic        if_err,
  input  logic        mem_req,
  input  logic [63:0] mem_addr,
  output logic        mem_ready,
  output logic [63:0] mem_rdata,
  output logic        mem_err,
  output logic [63:0] HADDR,
  output logic [63:0] HWDATA,
  input  logic [63:0] HRDATA,
  output logic        gnt_mem
);

  localparam logic [63:0] WIN_SPAN = 64'(ROM_SIZE) - 64'd4;
  localparam logic [3:0]  LIMIT    = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        grant;
  logic        win_mem;
  logic [63:0] win_addr;
  logic [63:0] win_offs;
  logic        win_ok;
  logic        err_q;
  logic [3:0]  starve_cnt;
  logic [3:0]  starve_nxt;

  assign HWDATA = 64'd0;

  assign win_addr = win_mem ? mem_addr : if_addr;
  // An address below ROM_START wraps to a huge offset, so one compare covers both bounds.
  assign win_offs = win_addr - ROM_START;
  assign win_ok   = (win_offs < WIN_SPAN);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    win_mem    = gnt_mem;
    starve_nxt = starve_cnt;
    case (state)
      IDLE: begin
        if (if_req || mem_req) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
          if (if_req && mem_req) begin
            if (starve_cnt == LIMIT) begin
              win_mem    = 1'b0;
              starve_nxt = 4'd0;
            end else begin
              win_mem = 1'b1;
              if (starve_cnt < LIMIT) begin
                starve_nxt = starve_cnt + 4'd1;
              end
            end
          end else if (mem_req) begin
            win_mem = 1'b1;
          end else begin
            win_mem    = 1'b0;
            starve_nxt = 4'd0;
          end
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      HADDR      <= 64'd0;
      gnt_mem    <= 1'b0;
      err_q      <= 1'b0;
      starve_cnt <= 4'd0;
      if_ready   <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= 64'd0;
      mem_ready  <= 1'b0;
      mem_err    <= 1'b0;
      mem_rdata  <= 64'd0;
    end else begin
      if_ready  <= 1'b0;
      if_err    <= 1'b0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      if (grant) begin
        gnt_mem    <= win_mem;
        err_q      <= !win_ok;
        starve_cnt <= starve_nxt;
        if (win_ok) begin
          HADDR <= win_addr;
        end
      end
      if (state == ACCESS) begin
        if (gnt_mem) begin
          mem_ready <= 1'b1;
          mem_err   <= err_q;
          mem_rdata <= err_q ? 64'd0 : HRDATA;
        end else begin
          if_ready <= 1'b1;
          if_err   <= err_q;
          if_rdata <= err_q ? 64'd0 : {32'd0, HRDATA[31:0]};
        end
      end
    end
  end

endmodule

// File: tb/tb_irom_arbiter.sv
// Bench for irom_arbiter: directed vector table, starvation and reset sequences,
// then random traffic against a transaction-level scheduling model.
module tb_irom_arbiter;

  logic        HCLK;
  logic        HRESET;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ready;
  logic [63:0] if_rdata;
  logic        if_err;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  logic        mem_err;
  logic [63:0] HADDR;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA;
  logic        gnt_mem;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int          LIMIT    = 4;
  localparam logic [63:0] WIN_LAST = 64'd252;

  irom_arbiter #(.ROM_SIZE(256), .ROM_START(64'h0), .STARVE_LIMIT(LIMIT)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rdata(if_rdata), .if_err(if_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .gnt_mem(gnt_mem)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic [7:0] rom_b(input int i);
    case (i)
      0: return 8'h93;
      1: return 8'h00;
      2: return 8'h00;
      3: return 8'h04;
      4: return 8'h13;
      5: return 8'h01;
      6: return 8'h80;
      7: return 8'h00;
      default: return (i >= 24) ? 8'(i) : 8'h00;
    endcase
  endfunction

  function automatic logic [63:0] rom_word(input logic [63:0] a);
    int b;
    b = int'(a[7:0]);
    return {32'd0, rom_b(b + 3), rom_b(b + 2), rom_b(b + 1), rom_b(b)};
  endfunction

  assign HRDATA = rom_word(HADDR);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7)       return 64'($urandom_range(0, 255));
    else if (r == 7) return 64'($urandom_range(256, 400));
    else if (r == 8) return 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(0, 255));
    else             return 64'($urandom_range(248, 255));
  endfunction

  typedef struct {
    bit          is_mem;
    logic [63:0] addr;
    logic [63:0] exp_data;
    bit          exp_err;
    logic [63:0] exp_haddr;
  } vec_t;

  vec_t vecs[9];

  // random-phase model state
  int          free_at, pend_at, exp_if_at, exp_mem_at, starve;
  logic [63:0] m_haddr, pend_haddr, m_if_rdata, m_mem_rdata;
  logic [63:0] exp_if_data, exp_mem_data;
  bit          m_gnt, pend_gnt, exp_if_err, exp_mem_err, if_busy, mem_busy;

  initial begin
    vecs[0] = '{1'b0, 64'h0,   64'h04000093, 1'b0, 64'h0};
    vecs[1] = '{1'b0, 64'h4,   64'h00800113, 1'b0, 64'h4};
    vecs[2] = '{1'b1, 64'h18,  64'h1B1A1918, 1'b0, 64'h18};
    vecs[3] = '{1'b1, 64'hFC,  64'h0,        1'b1, 64'h18};
    vecs[4] = '{1'b1, 64'hF8,  64'hFBFAF9F8, 1'b0, 64'hF8};
    vecs[5] = '{1'b1, 64'hFB,  64'hFEFDFCFB, 1'b0, 64'hFB};
    vecs[6] = '{1'b0, 64'h100, 64'h0,        1'b1, 64'hFB};
    vecs[7] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 1'b1, 64'hFB};
    vecs[8] = '{1'b0, 64'h1C,  64'h1F1E1D1C, 1'b0, 64'h1C};

    HRESET = 1'b1;
    if_req = 1'b0; if_addr = 64'd0;
    mem_req = 1'b0; mem_addr = 64'd0;
    #2;
    chk("rst_haddr", HADDR, 64'd0);
    chk("rst_ready", {62'd0, if_ready, mem_ready}, 64'd0);
    chk("rst_err", {62'd0, if_err, mem_err}, 64'd0);
    chk("rst_rdata", if_rdata | mem_rdata, 64'd0);
    chk("rst_gnt", {63'd0, gnt_mem}, 64'd0);
    chk("hwdata", HWDATA, 64'd0);
    @(posedge HCLK); @(posedge HCLK); #1;
    HRESET = 1'b0;

    // single-requester vector table
    for (int v = 0; v < 9; v++) begin
      if (vecs[v].is_mem) begin mem_req = 1'b1; mem_addr = vecs[v].addr; end
      else                begin if_req  = 1'b1; if_addr  = vecs[v].addr; end
      @(posedge HCLK); #1;
      chk($sformatf("v%0d_haddr", v), HADDR, vecs[v].exp_haddr);
      chk($sformatf("v%0d_gnt", v), {63'd0, gnt_mem}, {63'd0, vecs[v].is_mem});
      chk($sformatf("v%0d_early_rdy", v), {62'd0, if_ready, mem_ready}, 64'd0);
      @(posedge HCLK); #1;
      chk($sformatf("v%0d_rdy", v), {62'd0, if_ready, mem_ready},
          vecs[v].is_mem ? 64'd1 : 64'd2);
      chk($sformatf("v%0d_data", v), vecs[v].is_mem ? mem_rdata : if_rdata, vecs[v].exp_data);
      chk($sformatf("v%0d_err", v), {63'd0, vecs[v].is_mem ? mem_err : if_err},
          {63'd0, vecs[v].exp_err});
      @(posedge HCLK); #1;
      chk($sformatf("v%0d_done", v), {62'd0, if_ready, mem_ready}, 64'd0);
      if_req = 1'b0; mem_req = 1'b0;
    end

    // simultaneous requests: MEM first, IF three cycles later
    if_req = 1'b1; if_addr = 64'h4; mem_req = 1'b1; mem_addr = 64'h18;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    chk("both_mem_rdy", {62'd0, if_ready, mem_ready}, 64'd1);
    chk("both_mem_data", mem_rdata, 64'h1B1A1918);
    @(posedge HCLK); #1;
    mem_req = 1'b0;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    chk("both_if_rdy", {62'd0, if_ready, mem_ready}, 64'd2);
    chk("both_if_data", if_rdata, 64'h00800113);
    chk("both_if_err", {63'd0, if_err}, 64'd0);
    @(posedge HCLK); #1;
    if_req = 1'b0;

    // starvation guard: MEM x4, IF, MEM
    if_req = 1'b1; if_addr = 64'h0; mem_req = 1'b1; mem_addr = 64'h18;
    for (int i = 1; i <= 18; i++) begin
      @(posedge HCLK); #1;
      if ((i % 3) == 1)
        chk($sformatf("starve_gnt%0d", (i - 1) / 3), {63'd0, gnt_mem},
            ((i - 1) / 3 == LIMIT) ? 64'd0 : 64'd1);
      if ((i % 3) == 2)
        chk($sformatf("starve_rdy%0d", (i - 2) / 3), {62'd0, if_ready, mem_ready},
            ((i - 2) / 3 == LIMIT) ? 64'd2 : 64'd1);
      else
        chk($sformatf("starve_idle%0d", i), {62'd0, if_ready, mem_ready}, 64'd0);
    end
    if_req = 1'b0; mem_req = 1'b0;

    // async reset in the middle of ACCESS
    if_req = 1'b1; if_addr = 64'h4;
    @(posedge HCLK); #1;
    #2 HRESET = 1'b1;
    #1;
    chk("arst_haddr", HADDR, 64'd0);
    chk("arst_rdata", if_rdata | mem_rdata, 64'd0);
    chk("arst_flags", {60'd0, if_ready, mem_ready, if_err | mem_err, gnt_mem}, 64'd0);
    @(posedge HCLK); #3;
    HRESET = 1'b0;
    chk("arst_no_rdy0", {62'd0, if_ready, mem_ready}, 64'd0);
    @(posedge HCLK); #1;
    chk("arst_no_rdy1", {62'd0, if_ready, mem_ready}, 64'd0);
    chk("arst_haddr2", HADDR, 64'h4);
    @(posedge HCLK); #1;
    chk("arst_rdy", {62'd0, if_ready, mem_ready}, 64'd2);
    chk("arst_data", if_rdata, 64'h00800113);
    @(posedge HCLK); #1;
    if_req = 1'b0;

    // idle period
    for (int i = 0; i < 10; i++) begin
      @(posedge HCLK); #1;
      chk("idle_rdy", {62'd0, if_ready, mem_ready}, 64'd0);
      chk("idle_haddr", HADDR, 64'h4);
    end

    // random traffic vs. transaction-level model
    free_at = 0; pend_at = -100; exp_if_at = -100; exp_mem_at = -100; starve = 0;
    m_haddr = 64'h4; m_gnt = 1'b0; m_if_rdata = 64'h00800113; m_mem_rdata = 64'd0;
    exp_if_data = 64'd0; exp_mem_data = 64'd0; exp_if_err = 1'b0; exp_mem_err = 1'b0;
    pend_haddr = 64'd0; pend_gnt = 1'b0; if_busy = 1'b0; mem_busy = 1'b0;
    for (int c = 0; c < 600; c++) begin
      bit          wm, ok;
      logic [63:0] a;
      @(posedge HCLK); #1;
      if (c == pend_at) begin m_haddr = pend_haddr; m_gnt = pend_gnt; end
      if (c == exp_if_at)  m_if_rdata  = exp_if_data;
      if (c == exp_mem_at) m_mem_rdata = exp_mem_data;
      chk("rnd_if_ready", {63'd0, if_ready}, {63'd0, c == exp_if_at});
      chk("rnd_mem_ready", {63'd0, mem_ready}, {63'd0, c == exp_mem_at});
      if (c == exp_if_at)  chk("rnd_if_err", {63'd0, if_err}, {63'd0, exp_if_err});
      if (c == exp_mem_at) chk("rnd_mem_err", {63'd0, mem_err}, {63'd0, exp_mem_err});
      chk("rnd_if_rdata", if_rdata, m_if_rdata);
      chk("rnd_mem_rdata", mem_rdata, m_mem_rdata);
      chk("rnd_haddr", HADDR, m_haddr);
      chk("rnd_gnt", {63'd0, gnt_mem}, {63'd0, m_gnt});

      if (if_busy && c == exp_if_at + 1)   begin if_busy = 1'b0;  if_req = 1'b0;  end
      if (mem_busy && c == exp_mem_at + 1) begin mem_busy = 1'b0; mem_req = 1'b0; end
      if (!if_busy && $urandom_range(0, 99) < 50) begin
        if_busy = 1'b1; if_req = 1'b1; if_addr = rand_addr();
      end
      if (!mem_busy && $urandom_range(0, 99) < 50) begin
        mem_busy = 1'b1; mem_req = 1'b1; mem_addr = rand_addr();
      end

      if (c >= free_at && (if_req || mem_req)) begin
        if (if_req && mem_req) begin
          wm = (starve != LIMIT);
          starve = wm ? ((starve + 1 > LIMIT) ? LIMIT : starve + 1) : 0;
        end else begin
          wm = mem_req;
          if (!wm) starve = 0;
        end
        a  = wm ? mem_addr : if_addr;
        ok = (a < WIN_LAST);
        if (wm) begin
          exp_mem_at = c + 2; exp_mem_err = !ok; exp_mem_data = ok ? rom_word(a) : 64'd0;
        end else begin
          exp_if_at = c + 2; exp_if_err = !ok; exp_if_data = ok ? rom_word(a) : 64'd0;
        end
        pend_at = c + 1; pend_gnt = wm; pend_haddr = ok ? a : m_haddr;
        free_at = c + 3;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
